fft_result_reader: RTL and testbench

//  Read side of the FFT dual-port data memory: on start, sweeps all FFT_POINTS addresses, absorbs the

---
 rtl/fft_pkg.sv | 34 +++
 rtl/fft_out_fifo.sv | 55 +++++
 rtl/fft_result_reader.sv | 129 ++++++++++++
 tb/tb_fft_result_reader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT memory read-out path: default sizes,
// read-side FSM encoding and the address bit-reversal helper.
package fft_pkg;

  localparam int FFT_DATA_WIDTH = 16;
  localparam int FFT_POINTS_DEF = 64;
  localparam int FFT_ADDR_WIDTH = 6;

  // Output buffer depth; the issue rule keeps buffered + in-flight <= this.
  localparam int BUF_DEPTH = 4;
  localparam int BUF_CNT_W = 3;
  localparam int BUF_PTR_W = 2;

  // Widest address the bit-reversal helper supports.
  localparam int BITREV_MAX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Reverse the low 'width' bits of val; bits at and above 'width' come back zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] val,
                                                     input int unsigned width);
    logic [BITREV_MAX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      if (i < width) res[width-1-i] = val[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Four-entry synchronous FIFO holding {real, imag} samples between the
// memory read port and the streaming output. Head is visible while not empty.
module fft_out_fifo
  import fft_pkg::*;
#(
  parameter int WIDTH = 2 * FFT_DATA_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     head_o,
  output logic [BUF_CNT_W-1:0] count_o,
  output logic                 empty_o
);

  logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
  logic [BUF_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [BUF_CNT_W-1:0] count_q;
  logic                 full;
  logic                 do_push, do_pop;

  // Guard both ends so a misbehaving neighbour cannot corrupt the pointers.
  always_comb begin
    full    = (count_q == BUF_CNT_W'(BUF_DEPTH));
    empty_o = (count_q == '0);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full || do_pop);
    head_o  = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fft_result_reader.sv
// Unloads one FFT frame from the data memory read port and streams it out
// in natural bin order over valid/ready, absorbing the memory's one-cycle
// read latency through a small output FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; address held at 0, nothing in flight
// ST_READ  | issuing addresses while buffer + in-flight reads < 4
// ST_DRAIN | every address issued; emptying the buffer until out_last
module fft_result_reader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = FFT_DATA_WIDTH,
  parameter int FFT_POINTS  = FFT_POINTS_DEF,
  parameter int ADDR_WIDTH  = FFT_ADDR_WIDTH,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_real_i,
  input  logic [DATA_WIDTH-1:0] mem_data_imag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_real_o,
  output logic [DATA_WIDTH-1:0] out_imag_o,
  output logic [ADDR_WIDTH-1:0] out_index_o,
  output logic                  out_last_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FFT_POINTS - 1);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  inflight_q, inflight_d;
  logic                  done_q, done_d;

  logic                      issue;
  logic                      pop;
  logic                      last_hs;
  logic [2*DATA_WIDTH-1:0]   fifo_head;
  logic [BUF_CNT_W-1:0]      fifo_count;
  logic                      fifo_empty;

  // Data returned for the address issued last cycle lands in the buffer this cycle.
  fft_out_fifo #(
    .WIDTH (2 * DATA_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (inflight_q),
    .data_i  ({mem_data_real_i, mem_data_imag_i}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Output view of the buffer head and the bin counter.
  always_comb begin
    out_valid_o = !fifo_empty;
    out_real_o  = fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
    out_imag_o  = fifo_head[DATA_WIDTH-1:0];
    out_index_o = idx_q;
    out_last_o  = out_valid_o && (idx_q == LAST_IDX);
    busy_o      = (state_q != ST_IDLE);
    done_o      = done_q;
    mem_addr_o  = BIT_REVERSE ? ADDR_WIDTH'(bitrev(BITREV_MAX_W'(rd_cnt_q), ADDR_WIDTH))
                              : rd_cnt_q;
  end

  // Next-state: issue only depends on registered occupancy, never on out_ready.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    pop        = out_valid_o && out_ready_i;
    last_hs    = pop && (idx_q == LAST_IDX);
    idx_d      = pop ? ((idx_q == LAST_IDX) ? '0 : idx_q + 1'b1) : idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_READ;
          rd_cnt_d = '0;
        end
      end
      ST_READ: begin
        issue = ((fifo_count + BUF_CNT_W'(inflight_q)) < BUF_CNT_W'(BUF_DEPTH));
        if (issue) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    inflight_d = issue;
  end

  // State, counters, in-flight flag and done pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: bit-reversed instance under random backpressure,
// plus a natural-order instance with the sink always ready.
module tb_fft_result_reader;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk, rst_n;
  logic          start, out_ready, busy, done, out_valid, out_last;
  logic [AW-1:0] mem_addr, out_index;
  logic [DW-1:0] rd_re, rd_im, out_re, out_im;

  logic          start0, ready0, busy0, done0, valid0, last0;
  logic [AW-1:0] addr0, index0;
  logic [DW-1:0] rd_re0, rd_im0, out_re0, out_im0;

  logic [DW-1:0] mem_re [N];
  logic [DW-1:0] mem_im [N];

  int total = 0;
  int bad   = 0;

  fft_result_reader #(.DATA_WIDTH(DW), .FFT_POINTS(N), .ADDR_WIDTH(AW), .BIT_REVERSE(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
    .mem_addr_o(mem_addr), .mem_data_real_i(rd_re), .mem_data_imag_i(rd_im),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_real_o(out_re),
    .out_imag_o(out_im), .out_index_o(out_index), .out_last_o(out_last)
  );

  fft_result_reader #(.DATA_WIDTH(DW), .FFT_POINTS(N), .ADDR_WIDTH(AW), .BIT_REVERSE(1'b0)) dut_nat (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .busy_o(busy0), .done_o(done0),
    .mem_addr_o(addr0), .mem_data_real_i(rd_re0), .mem_data_imag_i(rd_im0),
    .out_valid_o(valid0), .out_ready_i(ready0), .out_real_o(out_re0),
    .out_imag_o(out_im0), .out_index_o(index0), .out_last_o(last0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memories: data for an address appears one cycle later.
  always @(posedge clk) begin
    rd_re  <= mem_re[mem_addr];
    rd_im  <= mem_im[mem_addr];
    rd_re0 <= DW'(addr0);
    rd_im0 <= DW'(-int'(addr0));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rev6(input int v);
    int r = 0;
    for (int i = 0; i < AW; i++) if (v[i]) r |= (1 << (AW - 1 - i));
    return r;
  endfunction

  task automatic load_ramp();
    for (int a = 0; a < N; a++) begin
      mem_re[a] = DW'(a);
      mem_im[a] = DW'(-a);
    end
  endtask

  task automatic load_random();
    for (int a = 0; a < N; a++) begin
      mem_re[a] = DW'($urandom);
      mem_im[a] = DW'($urandom);
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_addr", mem_addr, 0);
  endtask

  // Drives out_ready at pct% and checks every handshake against the frame
  // expected from memory contents: bin k carries mem[bitrev(k)].
  task automatic stream(input int pct, input int start_at, input int rst_at, output int cycles);
    int k = 0;
    int cyc = 0;
    int stall_bad = 0;
    int early_done = 0;
    int e;
    bit pulsed = 0;
    while (k < N && cyc < 1000) begin
      out_ready = ($urandom_range(0, 99) < pct);
      start = 1'b0;
      if (start_at >= 0 && k == start_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_index", out_index, 0);
        check("rst_real", out_re, 0);
        repeat (5) begin
          if (done) early_done++;
          tick();
        end
        check("rst_no_done", early_done, 0);
        check("rst_idle", busy, 0);
        cycles = cyc;
        return;
      end
      if (done) early_done++;
      // Reads issued (next bin to address) minus samples taken must stay within the buffer.
      if (rev6(int'(mem_addr)) - k > 4) stall_bad++;
      if (out_valid && out_ready) begin
        e = rev6(k);
        check("real", out_re, mem_re[e]);
        check("imag", out_im, mem_im[e]);
        check("index", out_index, k);
        check("last", out_last, (k == N - 1));
        k++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    cycles = cyc;
    check("frame_count", k, N);
    check("stall", stall_bad, 0);
    check("early_done", early_done, 0);
    check("done", done, 1);
    check("busy_end", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    int c;
    int last_edge;
    logic [DW-1:0] e_im;

    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; start0 = 1'b0; ready0 = 1'b1;
    load_ramp();
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", out_valid, 0);
    check("reset_last", out_last, 0);
    check("reset_index", out_index, 0);
    check("reset_real", out_re, 0);
    check("reset_imag", out_im, 0);
    check("reset_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();

    // Ramp data, sink always ready: latency and natural-order bit-reversed read-out.
    out_ready = 1'b1;
    start_frame();
    check("lat_e0", out_valid, 0);
    tick();
    check("lat_e1", out_valid, 0);
    tick();
    check("lat_e2", out_valid, 1);
    stream(100, -1, -1, cyc);
    check("span_br1", cyc + 2, N + 2);

    // Natural-order instance: out_real[k] == k, last handshake N+2 edges after start.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    k = 0; c = 0; last_edge = 0;
    while (k < N && c < 300) begin
      if (valid0) begin
        e_im = DW'(-k);
        check("nat_real", out_re0, k);
        check("nat_imag", out_im0, e_im);
        check("nat_index", index0, k);
        check("nat_last", last0, (k == N - 1));
        k++;
        if (k == N) last_edge = c + 1;
      end
      tick();
      c++;
    end
    check("nat_count", k, N);
    check("nat_span", last_edge, N + 2);
    check("nat_done", done0, 1);

    // Random data, 50% ready.
    load_random();
    start_frame();
    stream(50, -1, -1, cyc);

    // Sink stalled for 20 cycles: exactly four reads go out, head stays on bin 0.
    load_random();
    start_frame();
    out_ready = 1'b0;
    repeat (20) tick();
    check("bp_valid", out_valid, 1);
    check("bp_real", out_re, mem_re[0]);
    check("bp_imag", out_im, mem_im[0]);
    check("bp_index", out_index, 0);
    check("bp_addr", mem_addr, rev6(4));
    stream(100, -1, -1, cyc);

    // Start while busy is ignored; start in the done cycle launches the next frame.
    load_random();
    start_frame();
    stream(70, 10, -1, cyc);
    start_frame();
    stream(100, -1, -1, cyc);

    // Reset mid-frame abandons it; a fresh start restarts from bin 0.
    load_random();
    start_frame();
    stream(60, -1, 30, cyc);
    start_frame();
    stream(80, -1, -1, cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
